// File: rtl/router_pkg.sv
// Shared constants for the 1x3 packet router: byte width, FIFO depth,
// header field layout and destination port encodings.
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;

  localparam int LEN_MSB = DATA_W - 1;
  localparam int LEN_LSB = 2;
  localparam int DEST_W  = 2;

  typedef enum logic [DEST_W-1:0] {
    PORT0 = 2'b00,
    PORT1 = 2'b01,
    PORT2 = 2'b10
  } dest_e;

  function automatic dest_e hdr_dest(input logic [DATA_W-1:0] hdr);
    return dest_e'(hdr[DEST_W-1:0]);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for one router output FIFO:
// one write port, one registered read port, no reset.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: header-tagged byte storage,
// full/empty flags and a read-side packet length tracker.
module router_fifo #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_active
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = DATA_W - 1;
  localparam int LSB    = router_pkg::LEN_LSB;

  localparam logic [ADDR_W:0]  PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] bytes_left;
  logic             fresh_q;
  logic             zero_q;
  logic             wr_ok;
  logic             rd_ok;
  logic [DATA_W:0]  rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign wr_ok = write_enb && !full && !soft_reset;
  assign rd_ok = read_enb && !empty && !soft_reset;

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock  (clock),
    .we     (wr_ok),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data({lfd_state, data_in}),
    .re     (rd_ok),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_data(rd_word)
  );

  // The word popped last edge only becomes visible now, so its tag is
  // folded into the count here rather than before the edge.
  always_comb begin
    bytes_left = cnt_q;
    if (fresh_q) begin
      if (rd_word[DATA_W])
        bytes_left = {1'b0, rd_word[DATA_W-1:LSB]} + CNT_ONE;
      else if (cnt_q != '0)
        bytes_left = cnt_q - CNT_ONE;
    end
  end

  assign pkt_active = (bytes_left != '0);
  assign data_out   = zero_q ? '0 : rd_word[DATA_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        zero_q <= 1'b0;
      end
      cnt_q   <= bytes_left;
      fresh_q <= rd_ok;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus randomized
// bursts compared against a queue-based reference model.
module tb_router_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          soft_reset;
  logic          write_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic          read_enb;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          pkt_active;

  int passed = 0;
  int total  = 0;

  logic [DW:0]   q[$];
  logic [DW-1:0] m_dout;
  int            m_left;

  router_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .pkt_active(pkt_active)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    q.delete();
    m_dout = '0;
    m_left = 0;
  endtask

  // Drive one cycle and advance the reference model by its rules.
  task automatic step(input logic we, input logic lfd,
                      input logic [DW-1:0] din,
                      input logic re, input logic sr);
    bit          rd_acc;
    bit          wr_acc;
    logic [DW:0] e;
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = din;
    read_enb   = re;
    soft_reset = sr;
    @(posedge clock);
    if (sr) begin
      model_clear();
    end else begin
      rd_acc = re && (q.size() != 0);
      wr_acc = we && (q.size() != DP);
      if (rd_acc) begin
        e = q.pop_front();
        m_dout = e[DW-1:0];
        if (e[DW]) m_left = int'(e[DW-1:2]) + 1;
        else if (m_left != 0) m_left = m_left - 1;
      end
      if (wr_acc) q.push_back({lfd, din});
    end
    #1;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (data_out !== '0) $display("FAIL rst_dout got %0h want 0", data_out);
    else passed++;
    total++;
    if (empty !== 1'b1) $display("FAIL rst_empty got %0b want 1", empty);
    else passed++;
    total++;
    if (full !== 1'b0) $display("FAIL rst_full got %0b want 0", full);
    else passed++;
    total++;
    if (pkt_active !== 1'b0) $display("FAIL rst_pkt got %0b want 0", pkt_active);
    else passed++;
    reset = 1'b0;
    model_clear();
    step(1, 1, 8'h0C, 0, 0);
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++;
    if (pkt_active !== 1'b1 || data_out !== 8'h0C)
      $display("FAIL pre_async got %0b/%0h want 1/0c", pkt_active, data_out);
    else passed++;
    write_enb = 1'b1;
    data_in   = 8'h33;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (data_out !== '0 || empty !== 1'b1 || full !== 1'b0 ||
        pkt_active !== 1'b0)
      $display("FAIL async_rst got dout=%0h e=%0b f=%0b p=%0b want 0/1/0/0",
               data_out, empty, full, pkt_active);
    else passed++;
    @(posedge clock);
    #1;
    write_enb = 1'b0;
    reset     = 1'b0;
    model_clear();
    total++;
    if (empty !== 1'b1) $display("FAIL rst_nostore got %0b want 1", empty);
    else passed++;
  endtask

  task automatic test_packet();
    logic [DW-1:0] pkt [5];
    do_reset();
    pkt[0] = 8'h0C;
    for (int i = 1; i < 5; i++) pkt[i] = DW'($urandom);
    for (int i = 0; i < 5; i++) step(1, i == 0, pkt[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 0);
      total++;
      if (data_out !== pkt[i])
        $display("FAIL pkt_data[%0d] got %0h want %0h", i, data_out, pkt[i]);
      else passed++;
      total++;
      if (pkt_active !== (i < 4))
        $display("FAIL pkt_active[%0d] got %0b want %0b", i, pkt_active, i < 4);
      else passed++;
    end
    total++;
    if (empty !== 1'b1) $display("FAIL pkt_empty got %0b want 1", empty);
    else passed++;
  endtask

  task automatic test_fill();
    logic [DW-1:0] d [DP];
    do_reset();
    for (int i = 0; i < DP; i++) begin
      d[i] = DW'($urandom);
      step(1, 0, d[i], 0, 0);
    end
    total++;
    if (full !== 1'b1 || empty !== 1'b0)
      $display("FAIL fill_full got f=%0b e=%0b want 1/0", full, empty);
    else passed++;
    step(1, 0, 8'hA5, 0, 0);
    for (int i = 0; i < DP; i++) begin
      step(0, 0, 8'h00, 1, 0);
      total++;
      if (data_out !== d[i])
        $display("FAIL fill_rd[%0d] got %0h want %0h", i, data_out, d[i]);
      else passed++;
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL fill_empty got e=%0b f=%0b want 1/0", empty, full);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] first;
    logic [DW-1:0] held;
    do_reset();
    for (int i = 0; i < DP; i++) step(1, 0, DW'(i * 7 + 3), 0, 0);
    first = q[0][DW-1:0];
    step(1, 0, 8'hEE, 1, 0);
    total++;
    if (data_out !== first || full !== 1'b0 || q.size() != DP - 1)
      $display("FAIL sim_full got dout=%0h f=%0b want %0h/0",
               data_out, full, first);
    else passed++;
    while (q.size() != 0) begin
      step(0, 0, 8'h00, 1, 0);
      total++;
      if (data_out !== m_dout)
        $display("FAIL sim_drain got %0h want %0h", data_out, m_dout);
      else passed++;
    end
    total++;
    if (empty !== 1'b1) $display("FAIL sim_drained got %0b want 1", empty);
    else passed++;
    held = data_out;
    step(1, 0, 8'h5A, 1, 0);
    total++;
    if (empty !== 1'b0 || data_out !== held)
      $display("FAIL sim_empty got e=%0b dout=%0h want 0/%0h",
               empty, data_out, held);
    else passed++;
    step(0, 0, 8'h00, 1, 0);
    total++;
    if (data_out !== 8'h5A || empty !== 1'b1)
      $display("FAIL sim_empty_rd got %0h e=%0b want 5a/1", data_out, empty);
    else passed++;
  endtask

  task automatic test_wrap();
    int nw;
    int nr;
    do_reset();
    for (int b = 0; b < 40; b++) begin
      nw = $urandom_range(1, 12);
      nr = $urandom_range(1, 12);
      for (int i = 0; i < nw; i++)
        step(1, ($urandom_range(0, 3) == 0), DW'($urandom),
             ($urandom_range(0, 2) == 0), 0);
      for (int i = 0; i < nr; i++)
        step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
             DW'($urandom), 1, 0);
      total++;
      if (data_out !== m_dout || empty !== (q.size() == 0) ||
          full !== (q.size() == DP) || pkt_active !== (m_left != 0))
        $display("FAIL wrap[%0d] got d=%0h e=%0b f=%0b p=%0b want %0h/%0b/%0b/%0b",
                 b, data_out, empty, full, pkt_active, m_dout,
                 q.size() == 0, q.size() == DP, m_left != 0);
      else passed++;
    end
    while (q.size() != DP) step(1, 0, DW'($urandom), 0, 0);
    total++;
    if (full !== 1'b1) $display("FAIL wrap_full got %0b want 1", full);
    else passed++;
    while (q.size() != 0) step(0, 0, 8'h00, 1, 0);
    total++;
    if (empty !== 1'b1 || data_out !== m_dout)
      $display("FAIL wrap_empty got e=%0b d=%0h want 1/%0h",
               empty, data_out, m_dout);
    else passed++;
  endtask

  task automatic test_soft_reset();
    do_reset();
    step(1, 1, 8'h28, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, DW'(8'h40 + i), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++;
    if (pkt_active !== 1'b1 || q.size() != 7)
      $display("FAIL sr_pre got %0b want 1", pkt_active);
    else passed++;
    step(1, 0, 8'h99, 1, 1);
    total++;
    if (empty !== 1'b1 || data_out !== '0 || pkt_active !== 1'b0 ||
        full !== 1'b0)
      $display("FAIL sr_flush got e=%0b d=%0h p=%0b f=%0b want 1/0/0/0",
               empty, data_out, pkt_active, full);
    else passed++;
    step(1, 0, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++;
    if (data_out !== 8'h77 || empty !== 1'b1)
      $display("FAIL sr_after got %0h e=%0b want 77/1", data_out, empty);
    else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    read_enb   = 1'b0;
    model_clear();
    test_reset();
    test_packet();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_soft_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
